// File: rtl/seq_narrow_multiplier_pkg.sv
// Shared types and helpers for the sequential narrow-early-exit multiplier.
// Holds the FSM state encoding and a constant log2 helper for counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to represent values 0..value-1 (value>=1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEFAULT_WIDTH    = 8;
    // Iteration counter width for the default operand width
    localparam int DEFAULT_CNT_BITS = clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/seq_narrow_multiplier_adder.sv
// Ripple-carry adder built from full_adder cells, carry-in tied low.
// Forms the per-iteration partial-sum add of the shift-add multiplier.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry_out
);
    logic [N:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign carry_out = carry[N];
endmodule

// File: rtl/seq_narrow_multiplier.sv
// Iterative unsigned shift-add multiplier with valid/ready on both sides.
// Multipliers that fit in NARROW_WIDTH bits finish after NARROW_WIDTH iterations.
module seq_narrow_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NARROW_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 narrow,
    output logic [CNT_WIDTH-1:0] narrow_count
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam int ACC_W = 2 * WIDTH;
    localparam int SUM_W = WIDTH + 1;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;
    logic             flag;

    logic             is_narrow;
    logic [WIDTH-1:0] acc_slice;
    logic [SUM_W-1:0] sum;
    logic             carry_out;
    logic [ACC_W-1:0] slice_mask;
    logic [ACC_W-1:0] sum_shifted;
    logic [ACC_W-1:0] acc_next;

    assign is_narrow = ((b >> NARROW_WIDTH) == '0);
    assign in_ready  = (state == IDLE);

    // Partial sum below bit cnt+WIDTH is the only live part, so the add
    // window is acc[cnt +: WIDTH] plus mcand, written back WIDTH+2 bits wide.
    assign acc_slice = WIDTH'(acc >> cnt);

    ripple_carry_adder #(.N(SUM_W)) u_adder (
        .a         ({1'b0, acc_slice}),
        .b         ({1'b0, mcand}),
        .sum       (sum),
        .carry_out (carry_out)
    );

    assign slice_mask  = ACC_W'({(SUM_W + 1){1'b1}}) << cnt;
    assign sum_shifted = ACC_W'({carry_out, sum}) << cnt;
    assign acc_next    = mplier[0] ? ((acc & ~slice_mask) | sum_shifted) : acc;

    // NOTE: every register here uses <= so all reads in this block see
    // pre-edge values; blocking writes would reorder the datapath updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            cnt          <= '0;
            last_cnt     <= '0;
            flag         <= 1'b0;
            out_valid    <= 1'b0;
            product      <= '0;
            narrow       <= 1'b0;
            narrow_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        mplier   <= b;
                        acc      <= '0;
                        cnt      <= '0;
                        flag     <= is_narrow;
                        last_cnt <= is_narrow ? CNT_W'(NARROW_WIDTH - 1) : CNT_W'(WIDTH - 1);
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == last_cnt) begin
                        product   <= acc_next;
                        narrow    <= flag;
                        out_valid <= 1'b1;
                        if (flag && (narrow_count != '1))
                            narrow_count <= narrow_count + CNT_WIDTH'(1);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_narrow_multiplier.sv
// Scoreboard bench: the driver queues expected results on accept, a monitor
// compares product, narrow flag, latency and saturating count on each output.
module tb_seq_narrow_multiplier;

    localparam int W  = 8;
    localparam int NW = 4;
    localparam int CW = 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic            narrow;
    logic [CW-1:0]   narrow_count;

    seq_narrow_multiplier #(.WIDTH(W), .NARROW_WIDTH(NW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .narrow       (narrow),
        .narrow_count (narrow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] product;
        logic           narrow;
        int             accept_cyc;
        int             iters;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: present operands at a falling edge and hold until accepted.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   waited;
        waited   = 0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1");
                in_valid = 1'b0;
                return;
            end
        end
        e.product    = (2*W)'(int'(av) * int'(bv));
        e.narrow     = (int'(bv) < (1 << NW));
        e.iters      = e.narrow ? NW : W;
        e.accept_cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 || out_valid) begin
            @(negedge clk);
            waited++;
            if (waited > 300) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: pending=%0d required 0", sb_q.size());
                return;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor
    exp_t        mon_e;
    logic        prev_ov = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [2*W-1:0] held_p;
    logic        held_n;
    int          model_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            model_count = 0;
            prev_ov     = 1'b0;
            prev_rdy    = 1'b0;
        end else begin
            if (out_valid)
                check("in_ready_while_busy", 32'(in_ready), 32'd0);
            if (prev_ov && !prev_rdy) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_product", 32'(product), 32'(held_p));
                check("stall_narrow", 32'(narrow), 32'(held_n));
            end else if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: product=%0d with no op pending", product);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("product", 32'(product), 32'(mon_e.product));
                    check("narrow", 32'(narrow), 32'(mon_e.narrow));
                    check("latency", 32'(cyc - mon_e.accept_cyc), 32'(mon_e.iters));
                    if (mon_e.narrow && model_count < (1 << CW) - 1)
                        model_count++;
                    check("narrow_count", 32'(narrow_count), 32'(model_count));
                end
                held_p = product;
                held_n = narrow;
            end
            prev_ov  = out_valid;
            prev_rdy = out_ready;
        end
    end

    always @(negedge clk)
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_narrow", 32'(narrow), 32'd0);
        check("reset_count", 32'(narrow_count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Narrow and wide basics, including the narrow/wide boundary
        do_op(8'd13, 8'd11);   drain();
        do_op(8'd255, 8'd255); drain();
        do_op(8'd3, 8'd16);    drain();
        do_op(8'd3, 8'd15);    drain();
        do_op(8'd200, 8'd0);   drain();
        do_op(8'd0, 8'd200);   drain();

        // Consumer stall in DONE with new operands offered meanwhile
        out_ready = 1'b0;
        do_op(8'd200, 8'd100);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        do_op(8'd21, 8'd5); drain();

        // Reset in the middle of a calculation aborts it
        do_op(8'd100, 8'd200);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_product", 32'(product), 32'd0);
        check("midreset_count", 32'(narrow_count), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd7, 8'd9); drain();

        // Saturation of the narrow counter
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(W'($urandom), W'($urandom_range(0, 15)));
            drain();
        end
        check("count_saturated", 32'(narrow_count), 32'd3);

        // Randomized traffic with random backpressure
        rand_ready_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 0)
                do_op(W'($urandom), W'($urandom_range(0, 15)));
            else
                do_op(W'($urandom), W'($urandom));
        end
        rand_ready_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
